// File: rtl/vga_sync_if.sv
// vga_sync_if -- timing bundle produced by the VGA sync generator.
//   p_tick     : pixel-enable strobe, high one clk in every two
//   pix_x      : current horizontal count
//   pix_y      : current vertical count
//   video_on   : current pixel lies in the visible region
//   hsync      : horizontal sync, active low
//   vsync      : vertical sync, active low
//   line_tick  : pulse on the last pixel-enable of each line
//   frame_tick : pulse on the last pixel-enable of each frame
// The generator drives through the master modport; consumers use slave.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output p_tick, pix_x, pix_y, video_on, hsync, vsync, line_tick, frame_tick
  );

  modport slave (
    input p_tick, pix_x, pix_y, video_on, hsync, vsync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen -- VGA horizontal/vertical timing generator.
// A 1-bit divider turns the system clock into a pixel enable; the h counter
// advances on each enable, the v counter at the end of each line.
// Ports:
//   clk   : system clock (single domain)
//   reset : synchronous, active-high reset
//   vga   : vga_sync_if.master timing outputs (see vga_sync_if)
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // 10-bit constants so every counter comparison is width-matched.
  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       div_q;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       hsync_q;
  logic       vsync_q;
  logic       line_end;

  // Next-state counters. The sync flops are loaded from these so the sync
  // outputs change on the same edge as pix_x/pix_y.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    h_next = h_cnt;
    v_next = v_cnt;
    if (div_q) begin
      if (h_cnt == H_MAX) begin
        h_next = '0;
        v_next = (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
      end else begin
        h_next = h_cnt + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= ~div_q;
      h_cnt   <= h_next;
      v_cnt   <= v_next;
      hsync_q <= ~((h_next >= HS_START) && (h_next <= HS_END));
      vsync_q <= ~((v_next >= VS_START) && (v_next <= VS_END));
    end
  end

  assign line_end = div_q && (h_cnt == H_MAX);

  assign vga.p_tick     = div_q;
  assign vga.pix_x      = h_cnt;
  assign vga.pix_y      = v_cnt;
  assign vga.video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.line_tick  = line_end;
  assign vga.frame_tick = line_end && (v_cnt == V_MAX);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen -- directed, table-driven bench for vga_sync_gen.
// A full-size instance covers one line of the 640x480 timing; a reduced
// instance (15 x 8 counts, 240 clk per frame) covers frame-level behaviour
// and a reset taken in the middle of both sync pulses.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  vga_sync_if big_if ();
  vga_sync_if sml_if ();

  vga_sync_gen dut_big (
    .clk   (clk),
    .reset (reset),
    .vga   (big_if.master)
  );

  // Small timing: H 8+2+3+2=15 (hsync low at x 10..12),
  //               V 4+1+2+1=8  (vsync low at y 5..6).
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_sml (
    .clk   (clk),
    .reset (reset),
    .vga   (sml_if.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       p;
    logic       hs;
    logic       vs;
    logic       von;
    logic       lt;
    logic       ft;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl[NVEC];

  // Enter reset for n edges; return at a negedge with reset low, where the
  // DUT still holds its reset state (cycle 0).
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_big_reset_vals(input string tag);
    check({tag, " p_tick"},     int'(big_if.p_tick), 0);
    check({tag, " pix_x"},      int'(big_if.pix_x), 0);
    check({tag, " pix_y"},      int'(big_if.pix_y), 0);
    check({tag, " video_on"},   int'(big_if.video_on), 1);
    check({tag, " hsync"},      int'(big_if.hsync), 1);
    check({tag, " vsync"},      int'(big_if.vsync), 1);
    check({tag, " line_tick"},  int'(big_if.line_tick), 0);
    check({tag, " frame_tick"}, int'(big_if.frame_tick), 0);
  endtask

  initial begin
    // Cycle c = state after c edges since reset release.
    // pix_x = c/2 within the line; hsync low for x 656..751 -> clk 1312..1503.
    //            cyc   x    y  p hs vs von lt ft
    tbl[0]  = '{   0,   0,  0, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{   1,   0,  0, 1, 1, 1, 1, 0, 0};
    tbl[2]  = '{   2,   1,  0, 0, 1, 1, 1, 0, 0};
    tbl[3]  = '{1279, 639,  0, 1, 1, 1, 1, 0, 0};
    tbl[4]  = '{1280, 640,  0, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1311, 655,  0, 1, 1, 1, 0, 0, 0};
    tbl[6]  = '{1312, 656,  0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1503, 751,  0, 1, 0, 1, 0, 0, 0};
    tbl[8]  = '{1504, 752,  0, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{1598, 799,  0, 0, 1, 1, 0, 0, 0};
    tbl[10] = '{1599, 799,  0, 1, 1, 1, 0, 1, 0};
    tbl[11] = '{1600,   0,  1, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{1601,   0,  1, 1, 1, 1, 1, 0, 0};
    tbl[13] = '{1602,   1,  1, 0, 1, 1, 1, 0, 0};

    reset = 1'b1;
    do_reset(3);

    begin
      // Line-level statistics (big DUT, clk 0..1599).
      int hs_low = 0, von_hi = 0, lt_cnt = 0, lt_cyc = -1, x_err = 0;
      // Frame-level statistics (small DUT, clk 0..239).
      int ft_cnt = 0, ft_cyc = -1, s_vs_low = 0, s_hs_low = 0, s_von = 0;
      int s_von_bad = 0, s_hs_align = 0, s_vs_align = 0, s_range = 0, s_lt = 0;

      for (int c = 0; c <= 1602; c++) begin
        for (int i = 0; i < NVEC; i++) begin
          if (tbl[i].cyc == c) begin
            string t;
            t = $sformatf("line c=%0d", c);
            check({t, " pix_x"},      int'(big_if.pix_x), int'(tbl[i].x));
            check({t, " pix_y"},      int'(big_if.pix_y), int'(tbl[i].y));
            check({t, " p_tick"},     int'(big_if.p_tick), int'(tbl[i].p));
            check({t, " hsync"},      int'(big_if.hsync), int'(tbl[i].hs));
            check({t, " vsync"},      int'(big_if.vsync), int'(tbl[i].vs));
            check({t, " video_on"},   int'(big_if.video_on), int'(tbl[i].von));
            check({t, " line_tick"},  int'(big_if.line_tick), int'(tbl[i].lt));
            check({t, " frame_tick"}, int'(big_if.frame_tick), int'(tbl[i].ft));
          end
        end

        if (c < 1600) begin
          if (!big_if.hsync) hs_low++;
          if (big_if.video_on) von_hi++;
          if (big_if.line_tick) begin lt_cnt++; lt_cyc = c; end
          if (int'(big_if.pix_x) != c / 2) x_err++;
        end

        if (c < 240) begin
          int sx, sy;
          sx = int'(sml_if.pix_x);
          sy = int'(sml_if.pix_y);
          if (sml_if.frame_tick) begin ft_cnt++; ft_cyc = c; end
          if (sml_if.line_tick) s_lt++;
          if (!sml_if.vsync) s_vs_low++;
          if (!sml_if.hsync) s_hs_low++;
          if (sml_if.video_on) s_von++;
          if (sml_if.video_on && sy >= 4) s_von_bad++;
          if (sml_if.hsync !== !(sx >= 10 && sx <= 12)) s_hs_align++;
          if (sml_if.vsync !== !(sy >= 5 && sy <= 6)) s_vs_align++;
          if (sx > 14 || sy > 7) s_range++;
        end
        if (c == 240) begin
          check("frame wrap pix_x", int'(sml_if.pix_x), 0);
          check("frame wrap pix_y", int'(sml_if.pix_y), 0);
        end
        @(negedge clk);
      end

      check("line hsync low clk",    hs_low, 192);
      check("line video_on clk",     von_hi, 1280);
      check("line line_tick count",  lt_cnt, 1);
      check("line line_tick cycle",  lt_cyc, 1599);
      check("line pix_x step errs",  x_err, 0);
      check("frame frame_tick count", ft_cnt, 1);
      check("frame frame_tick cycle", ft_cyc, 239);
      check("frame line_tick count",  s_lt, 8);
      check("frame vsync low clk",    s_vs_low, 60);
      check("frame hsync low clk",    s_hs_low, 48);
      check("frame video_on clk",     s_von, 64);
      check("frame video_on y>=4",    s_von_bad, 0);
      check("frame hsync align errs", s_hs_align, 0);
      check("frame vsync align errs", s_vs_align, 0);
      check("frame range errs",       s_range, 0);
    end

    // Reset in the middle of both sync pulses (small DUT at x=11, y=5).
    do_reset(2);
    repeat (172) @(negedge clk);
    check("mid pre pix_x", int'(sml_if.pix_x), 11);
    check("mid pre pix_y", int'(sml_if.pix_y), 5);
    check("mid pre hsync", int'(sml_if.hsync), 0);
    check("mid pre vsync", int'(sml_if.vsync), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid rst pix_x",    int'(sml_if.pix_x), 0);
    check("mid rst pix_y",    int'(sml_if.pix_y), 0);
    check("mid rst hsync",    int'(sml_if.hsync), 1);
    check("mid rst vsync",    int'(sml_if.vsync), 1);
    check("mid rst p_tick",   int'(sml_if.p_tick), 0);
    check("mid rst video_on", int'(sml_if.video_on), 1);
    @(negedge clk);
    check("mid rel p_tick", int'(sml_if.p_tick), 1);
    check("mid rel pix_x",  int'(sml_if.pix_x), 0);
    @(negedge clk);
    check("mid rel2 pix_x", int'(sml_if.pix_x), 1);

    // Run a while, then hold reset for 10 clk: outputs must stay put.
    repeat (37) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_big_reset_vals($sformatf("hold %0d", i));
    end
    reset = 1'b0;
    check_big_reset_vals("hold rel c0");
    @(negedge clk);
    check("hold rel c1 p_tick", int'(big_if.p_tick), 1);
    check("hold rel c1 pix_x",  int'(big_if.pix_x), 0);
    @(negedge clk);
    check("hold rel c2 p_tick", int'(big_if.p_tick), 0);
    check("hold rel c2 pix_x",  int'(big_if.pix_x), 1);
    repeat (4) @(negedge clk);
    check("hold rel c6 pix_x",  int'(big_if.pix_x), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
REQ-004 Parameter H_BACK, 48, horizontal back porch (pixels).
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BACK, 33, vertical back porch (lines).
REQ-009 clk  input  1  system clock, 50 MHz; one clock domain only.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 p_tick  output  1  pixel-enable strobe, high one clk in every two.
REQ-012 pix_x  output  10  current horizontal count; 0..H_DISPLAY-1 is the visible region.
REQ-013 pix_y  output  10  current vertical count; 0..V_DISPLAY-1 is the visible region.
REQ-014 video_on  output  1  high when the current pixel is visible.
REQ-015 hsync  output  1  horizontal sync, active low, registered.
REQ-016 vsync  output  1  vertical sync, active low, registered.
REQ-017 line_tick  output  1  one-clk pulse on the last pixel-enable of each line.
REQ-018 frame_tick  output  1  one-clk pulse on the last pixel-enable of each frame.

Function
REQ-019 Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 A 1-bit divider toggles every clk; p_tick equals the divider register value.
REQ-021 The h counter advances only on clk edges where p_tick=1; at H_TOTAL-1 it wraps to 0.
REQ-022 The v counter advances only on edges where p_tick=1 and h=H_TOTAL-1; at V_TOTAL-1 it wraps to 0 together with h.
REQ-023 pix_x and pix_y are driven directly from the h and v counter registers; there is no added latency.
REQ-024 video_on = (pix_x < H_DISPLAY) AND (pix_y < V_DISPLAY); it is combinational from the counters.
REQ-025 hsync is low exactly while pix_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751].
REQ-026 vsync is low exactly while pix_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491].
REQ-027 hsync and vsync are flop outputs computed from next-state counter values, so they stay cycle-aligned with pix_x/pix_y and are glitch-free.
REQ-028 line_tick = p_tick AND (h = H_TOTAL-1).
REQ-029 frame_tick = line_tick AND (v = V_TOTAL-1).
REQ-030 Each counter value is held for exactly 2 clk; one line is 1600 clk; one frame is 840000 clk.
REQ-031 The counters never exceed their TOTAL-1; no out-of-range value is reachable.

Reset
REQ-032 While reset=1 at a clk edge, the following values load: divider 0, h 0, v 0, hsync 1, vsync 1.
REQ-033 During and after reset: p_tick=0, pix_x=0, pix_y=0, video_on=1, line_tick=0, frame_tick=0.
REQ-034 Reset asserted mid-frame or mid-sync-pulse forces the REQ-032 state on the next edge; no partial pulse persists beyond that edge.
REQ-035 The first p_tick=1 occurs on the first clk after reset deasserts; pix_x=1 follows on the next edge.

Verification
REQ-036 Reset, then run 1600 clk -> pix_x steps 0..799, 2 clk each; pix_y goes 0->1 exactly at clk 1600; line_tick is high once, at clk 1599.
REQ-037 Run 840000 clk from reset -> frame_tick is high exactly once (clk 839999); pix_x=0 and pix_y=0 at clk 840000.
REQ-038 Sample every p_tick over one line -> hsync is low for exactly 96 counts (656..751) = 192 clk; video_on is high for 640 counts.
REQ-039 Sample over one frame -> vsync is low for 2 lines (490, 491) = 3200 clk; video_on is 0 for all pix_y >= 480.
REQ-040 Assert reset for 1 clk at pix_x=700, pix_y=490 (hsync and vsync both low) -> next edge gives pix_x=0, pix_y=0, hsync=1, vsync=1, p_tick=0.
REQ-041 Hold reset for 10 clk -> all outputs stay at their REQ-033 values and counters do not move; normal counting resumes on release.
